// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, matrix size and the
// lock's key codes (row*4+col on a standard 1-2-3-A / *-0-#-D membrane pad).
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  typedef enum logic [3:0] {
    KEY_1    = 4'd0,  KEY_2 = 4'd1,  KEY_3    = 4'd2,  KEY_A = 4'd3,
    KEY_4    = 4'd4,  KEY_5 = 4'd5,  KEY_6    = 4'd6,  KEY_B = 4'd7,
    KEY_7    = 4'd8,  KEY_8 = 4'd9,  KEY_9    = 4'd10, KEY_C = 4'd11,
    KEY_STAR = 4'd12, KEY_0 = 4'd13, KEY_HASH = 4'd14, KEY_D = 4'd15
  } key_e;

  // Lowest-index active-low column; callers only use it when some column is low.
  function automatic logic [1:0] lowestLow(input logic [COLS-1:0] cols);
    lowestLow = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!cols[c]) lowestLow = 2'(c);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and code-entry-side signals of the scanner; the scanner is the
// master (drives rows and key events), the keypad/consumer side is the slave.
interface keypad_scanner_if;

  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (
    input  col_in,
    output row_out,
    output key_code,
    output key_valid
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_code,
    input  key_valid
  );

endinterface

// File: rtl/row_strobe.sv
// Active-low row strobe: holds each row SCAN_DIV cycles, flags the last cycle
// of a row period, and stops (row and divider) while freeze_i is high.
module row_strobe
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze_i,
  output logic [1:0] rowIdx_o,
  output logic [3:0] rowOut_o,
  output logic       endOfRow_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;

  // A frozen strobe parks on the last cycle of its period, so the first
  // unfrozen cycle steps straight to the next row.
  always_comb begin
    div_d      = div_q;
    row_d      = row_q;
    endOfRow_o = (div_q == DIV_LAST);
    if (!freeze_i) begin
      if (endOfRow_o) begin
        div_d = '0;
        row_d = row_q + 2'd1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      row_q <= '0;
    end else begin
      div_q <= div_d;
      row_q <= row_d;
    end
  end

  assign rowIdx_o = row_q;
  assign rowOut_o = ~(ROWS'(1) << row_q);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synchronizes and debounces the column returns and emits
// one key event per press. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 200000,
  parameter int REPEAT_CYC   = 50000000
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master kp
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [3:0] sync1_q, colS_q;
  state_e     state_q, state_d;
  logic [1:0] candRow_q, candRow_d, candCol_q, candCol_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] keyCode_q, keyCode_d;
  logic       keyValid_q, keyValid_d;
  logic       candLow, freeze, endOfRow;
  logic [1:0] rowIdx;
  logic [3:0] rowOut;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] rpt_q, rpt_d;
`else
  localparam int unusedRepeatCyc = REPEAT_CYC;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b1111;
      colS_q  <= 4'b1111;
    end else begin
      sync1_q <= kp.col_in;
      colS_q  <= sync1_q;
    end
  end

  assign candLow = ~colS_q[candCol_q];
  // Freeze on the decision cycle itself so the candidate row stays driven.
  assign freeze  = (state_d != SCAN);

  row_strobe #(.SCAN_DIV(SCAN_DIV)) u_row_strobe (
    .clk       (clk),
    .reset     (reset),
    .freeze_i  (freeze),
    .rowIdx_o  (rowIdx),
    .rowOut_o  (rowOut),
    .endOfRow_o(endOfRow)
  );

  always_comb begin
    state_d    = state_q;
    candRow_d  = candRow_q;
    candCol_d  = candCol_q;
    cnt_d      = cnt_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d      = '0;
`endif
    case (state_q)
      SCAN: begin
        if (endOfRow && (colS_q != 4'b1111)) begin
          candRow_d = rowIdx;
          candCol_d = lowestLow(colS_q);
          cnt_d     = '0;
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!candLow) begin
          state_d = SCAN;
        end else if (cnt_q == DB_LAST) begin
          keyCode_d  = {candRow_q, candCol_q};
          keyValid_d = 1'b1;
          cnt_d      = '0;
          state_d    = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (candLow) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`ifdef KEYPAD_REPEAT_EN
        if (candLow) begin
          if (rpt_q == RPT_LAST) begin
            rpt_d      = '0;
            keyValid_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end else if (state_d == HELD) begin
          rpt_d = rpt_q;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SCAN;
      candRow_q  <= '0;
      candCol_q  <= '0;
      cnt_q      <= '0;
      keyCode_q  <= '0;
      keyValid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      candRow_q  <= candRow_d;
      candCol_q  <= candCol_d;
      cnt_q      <= cnt_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q      <= rpt_d;
`endif
    end
  end

  assign kp.row_out   = rowOut;
  assign kp.key_code  = keyCode_q;
  assign kp.key_valid = keyValid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model closes the row/column
// loop, stimulus queues expected key events, a negedge monitor checks them.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 8;
  localparam int REPEAT_CYC   = 32;
  localparam int LAT_MAX      = 4 * SCAN_DIV + 2 + DEBOUNCE_CYC;

  typedef struct {
    logic [3:0] code;
    int         lo;
    int         hi;
    int         gap;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] pressed;
  int          cycle = 0;
  int          nVectors = 0;
  int          nMiss = 0;
  int          lastValid = 0;
  int          markP;
  exp_t        expQ[$];
  exp_t        got;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_CYC  (REPEAT_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Membrane matrix: a pressed key pulls its column low while its row is strobed.
  always_comb begin
    kif.col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!kif.row_out[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r * 4 + c]) kif.col_in[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && kif.key_valid === 1'b1) begin
      nVectors++;
      if (expQ.size() == 0) begin
        nMiss++;
        $display("[TB] FAIL spurious_valid: got key_valid=1 key_code=%0d at cycle %0d, required no event",
                 kif.key_code, cycle);
      end else begin
        got = expQ.pop_front();
        if (kif.key_code !== got.code || cycle < got.lo || cycle > got.hi ||
            (got.gap > 0 && cycle - lastValid != got.gap)) begin
          nMiss++;
          $display("[TB] FAIL key_event: got code=%0d cycle=%0d gap=%0d, required code=%0d cycle in [%0d,%0d] gap=%0d",
                   kif.key_code, cycle, cycle - lastValid, got.code, got.lo, got.hi, got.gap);
        end
      end
      lastValid = cycle;
    end
  end

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
    nVectors++;
    if (act !== req) begin
      nMiss++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic expectKey(input logic [3:0] code, input int lo, input int hi, input int gap);
    exp_t e;
    e.code = code;
    e.lo   = lo;
    e.hi   = hi;
    e.gap  = gap;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitRowStart(input int row);
    logic [3:0] pat;
    logic [3:0] prev;
    bit         found;
    pat   = ~(4'b0001 << row);
    prev  = kif.row_out;
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      waitCycles(1);
      if (kif.row_out == pat && prev != pat) found = 1;
      prev = kif.row_out;
    end
    if (!found) begin
      nVectors++;
      nMiss++;
      $display("[TB] FAIL row_start_timeout: got row_out=%b, required start of %b", kif.row_out, pat);
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    int k;
    k = 0;
    while (expQ.size() > 0 && k < maxCycles) begin
      waitCycles(1);
      k++;
    end
    nVectors++;
    if (expQ.size() != 0) begin
      nMiss++;
      $display("[TB] FAIL event_timeout: got %0d events still pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    logic [3:0] pat;
    int         relC;
    reset = 1'b1;
    applyStimulus(16'h0000);
    waitCycles(3);
    checkOutput("reset_row_out", kif.row_out, 4'b1110);
    checkOutput("reset_key_code", kif.key_code, 4'd0);
    checkOutput("reset_key_valid", {3'b000, kif.key_valid}, 4'd0);
    reset = 1'b0;

    // Idle scan: rotation and wrap, four cycles per row
    for (int k = 0; k < 40; k++) begin
      pat = ~(4'b0001 << ((k / 4) % 4));
      checkOutput($sformatf("idle_row_%0d", k), kif.row_out, pat);
      waitCycles(1);
    end

    // Key 6 held, single event, resume at the next row after release
    expectKey(4'd6, cycle, cycle + LAT_MAX, 0);
    applyStimulus(16'h0040);
    waitDrain(LAT_MAX + 4);
    waitCycles(16);
    relC = cycle;
    applyStimulus(16'h0000);
    waitCycles(9);
    checkOutput("release_row_frozen", kif.row_out, 4'b1101);
    waitCycles(1);
    checkOutput("release_resume_row", kif.row_out, 4'b1011);
    if (cycle != relC + 10) begin
      nVectors++;
      nMiss++;
      $display("[TB] FAIL release_timing: got %0d cycles, required 10", cycle - relC);
    end

    // Bounce on key 6: three low cycles, no event
    waitRowStart(1);
    applyStimulus(16'h0040);
    waitCycles(3);
    applyStimulus(16'h0000);
    waitCycles(1);
    checkOutput("bounce_row_frozen", kif.row_out, 4'b1101);
    waitCycles(2);
    checkOutput("bounce_resume_row", kif.row_out, 4'b1011);
    waitCycles(20);

    // Codes 9 and 11 together in row 2: lowest column wins
    expectKey(4'd9, cycle, cycle + LAT_MAX, 0);
    applyStimulus(16'h0A00);
    waitDrain(LAT_MAX + 4);
    waitCycles(10);
    applyStimulus(16'h0000);
    waitCycles(20);

    // Release glitch while held: no new event, row stays frozen
    waitRowStart(1);
    markP = cycle;
    expectKey(4'd6, markP + 12, markP + 12, 0);
    applyStimulus(16'h0040);
    waitDrain(LAT_MAX + 4);
    waitCycles(2);
    applyStimulus(16'h0000);
    waitCycles(2);
    applyStimulus(16'h0040);
    waitCycles(10);
    checkOutput("glitch_still_held", kif.row_out, 4'b1101);
    applyStimulus(16'h0000);
    waitCycles(20);

    // Reset in the middle of a debounce
    waitRowStart(1);
    applyStimulus(16'h0040);
    waitCycles(5);
    checkOutput("pre_reset_frozen", kif.row_out, 4'b1101);
    reset = 1'b1;
    applyStimulus(16'h0000);
    #1;
    checkOutput("mid_reset_row_out", kif.row_out, 4'b1110);
    checkOutput("mid_reset_key_valid", {3'b000, kif.key_valid}, 4'd0);
    waitCycles(3);
    reset = 1'b0;
    waitCycles(40);

    // Key 0 held 100 cycles from the start of row 0
    waitRowStart(0);
    markP = cycle;
    expectKey(4'd0, markP + 12, markP + 12, 0);
`ifdef KEYPAD_REPEAT_EN
    expectKey(4'd0, 0, 1 << 30, REPEAT_CYC);
    expectKey(4'd0, 0, 1 << 30, REPEAT_CYC);
`endif
    applyStimulus(16'h0001);
    waitCycles(100);
    applyStimulus(16'h0000);
    waitDrain(20);
    waitCycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
